pipe_stage_chain: RTL and testbench

Parametrised chain of NUM_STAGES pipeline registers with per-stage valid bits, stall and flush controls, and automatic back-pressure propagation. Replaces hand-written per-boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Inserts a bubble downstream of a held stage and can optionally collapse bubbles so that a stalled stage does not freeze empty stages upstream of it. Exposes every stage's contents to the hazard and forwarding logic, plus a front-end stall counter.

---
 rtl/pipe_stage_chain_pkg.sv | 20 ++
 rtl/pipe_stage_chain_stage.sv | 45 ++++
 rtl/pipe_stage_chain.sv | 100 ++++++++++
 tb/tb_pipe_stage_chain.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and helpers for the generic pipeline-register chain.
package pipe_stage_chain_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0); IF/ID instances use it as their flush payload.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Widest valid vector popcount() accepts; chains longer than this are not supported.
  localparam int unsigned MaxStages = 64;

  // Number of set bits in vec.
  function automatic int unsigned popcount(input logic [MaxStages-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(MaxStages); i++) begin
      cnt = cnt + {31'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_stage_chain_stage.sv
// One register stage: valid bit plus payload.
// Update priority is flush, then hold, then bubble, then load.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W     = 64,
  parameter logic [DATA_W-1:0]  FLUSH_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Stage contents; flush wins over hold so a stalled wrong-path entry can still be killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= FLUSH_DATA;
    end else if (flush) begin
      valid_q <= 1'b0;
      data_q  <= FLUSH_DATA;
    end else if (hold) begin
      valid_q <= valid_q;
      data_q  <= data_q;
    end else if (bubble) begin
      // Predecessor is holding: take nothing rather than a copy of its entry.
      valid_q <= 1'b0;
      data_q  <= FLUSH_DATA;
    end else begin
      valid_q <= load_valid;
      data_q  <= load_data;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Generic chain of pipeline registers with stall, flush, back-pressure and optional
// bubble collapsing. Exposes every stage to hazard/forwarding logic.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int unsigned        NUM_STAGES       = 4,
  parameter int unsigned        DATA_W           = 64,
  parameter logic [DATA_W-1:0]  FLUSH_DATA       = '0,
  parameter bit                 COLLAPSE_BUBBLES = 1'b1,
  parameter int unsigned        CNT_W            = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic [NUM_STAGES-1:0]               stall_req,
  input  logic [NUM_STAGES-1:0]               flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W-1:0]                   out_data,
  output logic [NUM_STAGES-1:0]               stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0]        stage_data,
  output logic [NUM_STAGES-1:0]               hold_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]     occupancy,
  output logic [CNT_W-1:0]                    front_stall_cnt
);

  localparam int unsigned OccW = $clog2(NUM_STAGES + 1);

  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] bubble;
  logic [NUM_STAGES-1:0] prev_valid;
  logic [DATA_W-1:0]     data_arr  [NUM_STAGES];
  logic [DATA_W-1:0]     prev_data [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_q;

  // Back-pressure chain, walked from the output end towards stage 0.
  always_comb begin
    logic h;
    hold = '0;
    h = stall_req[NUM_STAGES-1] | (valid[NUM_STAGES-1] & ~out_ready);
    hold[NUM_STAGES-1] = h;
    for (int i = int'(NUM_STAGES) - 2; i >= 0; i--) begin
      // An empty stage can absorb its predecessor's entry when collapsing is enabled.
      h = stall_req[i] | (h & (valid[i] | ~COLLAPSE_BUBBLES));
      hold[i] = h;
    end
  end

  // Per-stage load sources and bubble requests.
  always_comb begin
    prev_valid    = '0;
    bubble        = '0;
    prev_valid[0] = in_valid;
    prev_data[0]  = in_data;
    for (int i = 1; i < int'(NUM_STAGES); i++) begin
      prev_valid[i] = valid[i-1];
      prev_data[i]  = data_arr[i-1];
      bubble[i]     = hold[i-1];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    pipe_stage_reg #(
      .DATA_W     (DATA_W),
      .FLUSH_DATA (FLUSH_DATA)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush[g]),
      .hold       (hold[g]),
      .bubble     (bubble[g]),
      .load_valid (prev_valid[g]),
      .load_data  (prev_data[g]),
      .valid      (valid[g]),
      .data       (data_arr[g])
    );
    assign stage_data[g*DATA_W +: DATA_W] = data_arr[g];
  end

  // Saturating count of cycles where upstream offers data that stage 0 cannot take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (in_valid && hold[0] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready        = ~hold[0];
  assign out_valid       = valid[NUM_STAGES-1];
  assign out_data        = data_arr[NUM_STAGES-1];
  assign stage_valid     = valid;
  assign hold_o          = hold;
  assign front_stall_cnt = cnt_q;
  assign occupancy       = OccW'(popcount(MaxStages'(valid)));

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench: directed scenarios plus randomized traffic against a reference model.
module tb_pipe_stage_chain;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned OW = $clog2(N + 1);
  localparam logic [W-1:0] FD = 32'h13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [N-1:0]  stall_req = '0;
  logic [N-1:0]  flush = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [N-1:0]  stage_valid, hold_o;
  logic [N*W-1:0] stage_data;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] front_stall_cnt;

  logic          b_in_ready, b_out_valid;
  logic [W-1:0]  b_out_data;
  logic [N-1:0]  b_stage_valid, b_hold_o;
  logic [N*W-1:0] b_stage_data;
  logic [OW-1:0] b_occupancy;
  logic [CW-1:0] b_front_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .NUM_STAGES(N), .DATA_W(W), .FLUSH_DATA(FD), .COLLAPSE_BUBBLES(1'b1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .stall_req(stall_req), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .stage_valid(stage_valid), .stage_data(stage_data), .hold_o(hold_o),
    .occupancy(occupancy), .front_stall_cnt(front_stall_cnt)
  );

  pipe_stage_chain #(
    .NUM_STAGES(N), .DATA_W(W), .FLUSH_DATA(FD), .COLLAPSE_BUBBLES(1'b0), .CNT_W(CW)
  ) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .stall_req(stall_req), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .stage_valid(b_stage_valid), .stage_data(b_stage_data),
    .hold_o(b_hold_o), .occupancy(b_occupancy), .front_stall_cnt(b_front_stall_cnt)
  );

  function automatic logic [W-1:0] sd(input int i);
    return stage_data[i*W +: W];
  endfunction

  task automatic set_in(input logic iv, input logic [W-1:0] id, input logic [N-1:0] sr,
                        input logic [N-1:0] fl, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    stall_req = sr;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a clock edge with reset released.
  task automatic do_reset();
    set_in(1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_in(1'b1, 32'h55, '0, '0, 1'b0);
    repeat (6) edge_step();
    // Four accepting edges fill the pipe, the last two are front-end stalls.
    n_checks++;
    if (front_stall_cnt !== 4'd2) begin
      n_errors++; $display("FAIL reset_pre_cnt: got %0d expected 2", front_stall_cnt);
    end
    n_checks++;
    if (b_front_stall_cnt !== 4'd2) begin
      n_errors++; $display("FAIL reset_pre_cnt_nc: got %0d expected 2", b_front_stall_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (stage_valid !== 4'b0000) begin
      n_errors++; $display("FAIL reset_valid: got %b expected 0000", stage_valid);
    end
    for (int i = 0; i < int'(N); i++) begin
      n_checks++;
      if (sd(i) !== FD) begin
        n_errors++; $display("FAIL reset_data[%0d]: got %h expected %h", i, sd(i), FD);
      end
    end
    n_checks++;
    if (occupancy !== '0) begin
      n_errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (front_stall_cnt !== '0) begin
      n_errors++; $display("FAIL reset_cnt: got %0d expected 0", front_stall_cnt);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    stall_req = 4'b0001;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_ready_stall: got %b expected 0", in_ready);
    end
    stall_req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic          exp_v;
    logic [W-1:0]  exp_d;
    logic [OW-1:0] exp_occ;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      if (k <= 6) set_in(1'b1, 32'hA0 + 32'(k) - 32'd1, '0, '0, 1'b1);
      else        set_in(1'b0, '0, '0, '0, 1'b1);
      edge_step();
      // Item j is captured at edge j+1 and sits in stage k-1-j after edge k.
      exp_v = (k >= 4) && (k <= 9);
      exp_d = 32'hA0 + 32'(k) - 32'd4;
      exp_occ = '0;
      for (int j = 0; j < 6; j++) begin
        if ((k - 1 - j >= 0) && (k - 1 - j <= 3)) exp_occ = exp_occ + 1'b1;
      end
      n_checks++;
      if (out_valid !== exp_v) begin
        n_errors++; $display("FAIL stream_out_valid@%0d: got %b expected %b", k, out_valid, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (out_data !== exp_d) begin
          n_errors++; $display("FAIL stream_out_data@%0d: got %h expected %h", k, out_data, exp_d);
        end
      end
      n_checks++;
      if (occupancy !== exp_occ) begin
        n_errors++; $display("FAIL stream_occ@%0d: got %0d expected %0d", k, occupancy, exp_occ);
      end
    end
  endtask

  task automatic test_mid_stall();
    logic [W-1:0] q [$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 32'hB0 + 32'(k), '0, '0, 1'b1);
      edge_step();
      if (out_valid) q.push_back(out_data);
    end
    set_in(1'b1, 32'hB4, 4'b0010, '0, 1'b1);
    #1;
    n_checks++;
    if (hold_o !== 4'b0011) begin
      n_errors++; $display("FAIL stall_hold: got %b expected 0011", hold_o);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready);
    end
    edge_step();
    if (out_valid) q.push_back(out_data);
    n_checks++;
    if (stage_valid !== 4'b1011) begin
      n_errors++; $display("FAIL stall_bubble_valid: got %b expected 1011", stage_valid);
    end
    n_checks++;
    if (sd(2) !== FD) begin
      n_errors++; $display("FAIL stall_bubble_data: got %h expected %h", sd(2), FD);
    end
    for (int k = 4; k < 8; k++) begin
      set_in(1'b1, 32'hB0 + 32'(k), '0, '0, 1'b1);
      edge_step();
      if (out_valid) q.push_back(out_data);
    end
    for (int k = 0; k < 6; k++) begin
      set_in(1'b0, '0, '0, '0, 1'b1);
      edge_step();
      if (out_valid) q.push_back(out_data);
    end
    n_checks++;
    if (q.size() != 8) begin
      n_errors++; $display("FAIL stall_out_count: got %0d expected 8", q.size());
    end
    for (int i = 0; i < q.size() && i < 8; i++) begin
      n_checks++;
      if (q[i] !== 32'hB0 + 32'(i)) begin
        n_errors++; $display("FAIL stall_order[%0d]: got %h expected %h", i, q[i], 32'hB0 + 32'(i));
      end
    end
  endtask

  task automatic test_collapse();
    do_reset();
    set_in(1'b1, 32'hC0, '0, '0, 1'b0); edge_step();
    set_in(1'b0, '0,     '0, '0, 1'b0); edge_step();
    set_in(1'b1, 32'hC1, '0, '0, 1'b0); edge_step();
    set_in(1'b1, 32'hC2, '0, '0, 1'b0); edge_step();
    n_checks++;
    if (stage_valid !== 4'b1011) begin
      n_errors++; $display("FAIL collapse_setup: got %b expected 1011", stage_valid);
    end
    set_in(1'b1, 32'hC3, '0, '0, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL collapse_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (hold_o !== 4'b1000) begin
      n_errors++; $display("FAIL collapse_hold: got %b expected 1000", hold_o);
    end
    n_checks++;
    if (b_in_ready !== 1'b0) begin
      n_errors++; $display("FAIL nocollapse_in_ready: got %b expected 0", b_in_ready);
    end
    n_checks++;
    if (b_hold_o !== 4'b1111) begin
      n_errors++; $display("FAIL nocollapse_hold: got %b expected 1111", b_hold_o);
    end
    n_checks++;
    if (b_occupancy !== 3'd3) begin
      n_errors++; $display("FAIL nocollapse_occ: got %0d expected 3", b_occupancy);
    end
    n_checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'hC0) begin
      n_errors++; $display("FAIL nocollapse_out: got %b/%h expected 1/c0", b_out_valid, b_out_data);
    end
    edge_step();
    n_checks++;
    if (stage_valid !== 4'b1111) begin
      n_errors++; $display("FAIL collapse_fill: got %b expected 1111", stage_valid);
    end
    n_checks++;
    if (sd(2) !== 32'hC1) begin
      n_errors++; $display("FAIL collapse_s2: got %h expected c1", sd(2));
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL collapse_next_ready: got %b expected 0", in_ready);
    end
    n_checks++;
    if (b_stage_valid !== 4'b1011) begin
      n_errors++; $display("FAIL nocollapse_frozen: got %b expected 1011", b_stage_valid);
    end
    n_checks++;
    if (b_stage_data[3*W +: W] !== 32'hC0) begin
      n_errors++; $display("FAIL nocollapse_s3: got %h expected c0", b_stage_data[3*W +: W]);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] q [$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 32'hD0 + 32'(k), '0, '0, 1'b1);
      edge_step();
    end
    set_in(1'b0, '0, 4'b0100, 4'b0100, 1'b1);
    #1;
    n_checks++;
    if (hold_o !== 4'b0111) begin
      n_errors++; $display("FAIL flush_hold: got %b expected 0111", hold_o);
    end
    edge_step();
    n_checks++;
    if (stage_valid !== 4'b0011) begin
      n_errors++; $display("FAIL flush_beats_hold_valid: got %b expected 0011", stage_valid);
    end
    n_checks++;
    if (sd(2) !== FD) begin
      n_errors++; $display("FAIL flush_s2_data: got %h expected %h", sd(2), FD);
    end
    set_in(1'b1, 32'hE0, '0, 4'b0001, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL flush0_in_ready: got %b expected 1", in_ready);
    end
    edge_step();
    n_checks++;
    if (stage_valid !== 4'b0110) begin
      n_errors++; $display("FAIL flush0_valid: got %b expected 0110", stage_valid);
    end
    n_checks++;
    if (sd(0) !== FD) begin
      n_errors++; $display("FAIL flush0_data: got %h expected %h", sd(0), FD);
    end
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, '0, '0, '0, 1'b1);
      edge_step();
      if (out_valid) q.push_back(out_data);
    end
    n_checks++;
    if (q.size() != 2) begin
      n_errors++; $display("FAIL flush_out_count: got %0d expected 2", q.size());
    end else begin
      n_checks++;
      if (q[0] !== 32'hD2 || q[1] !== 32'hD3) begin
        n_errors++; $display("FAIL flush_out_seq: got %h,%h expected d2,d3", q[0], q[1]);
      end
    end
  endtask

  task automatic test_counter();
    int unsigned exp;
    do_reset();
    set_in(1'b1, 32'hC0DE, '0, '0, 1'b0);
    repeat (4) edge_step();
    n_checks++;
    if (front_stall_cnt !== '0) begin
      n_errors++; $display("FAIL cnt_fill: got %0d expected 0", front_stall_cnt);
    end
    for (int k = 1; k <= 20; k++) begin
      edge_step();
      exp = (k > 15) ? 15 : k;
      n_checks++;
      if (front_stall_cnt !== CW'(exp)) begin
        n_errors++; $display("FAIL cnt_sat@%0d: got %0d expected %0d", k, front_stall_cnt, exp);
      end
    end
  endtask

  // Randomized traffic; the model applies the hold rule and per-stage priority directly.
  task automatic test_random();
    logic          mv [N];
    logic [W-1:0]  md [N];
    logic          nv [N];
    logic [W-1:0]  nd [N];
    logic          mh [N];
    logic [N-1:0]  mvp, mhp, sr, fl;
    int unsigned   mcnt, occ;
    logic          iv, ordy;
    logic [W-1:0]  id;
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      mv[i] = 1'b0; md[i] = FD;
    end
    mcnt = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      iv = ($urandom_range(0, 3) != 0);
      id = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(N); i++) begin
        sr[i] = ($urandom_range(0, 7) == 0);
        fl[i] = ($urandom_range(0, 15) == 0);
      end
      set_in(iv, id, sr, fl, ordy);
      #1;
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (i == int'(N) - 1) mh[i] = sr[i] | (mv[i] & ~ordy);
        else                  mh[i] = sr[i] | (mh[i+1] & mv[i]);
      end
      occ = 0;
      for (int i = 0; i < int'(N); i++) begin
        mvp[i] = mv[i]; mhp[i] = mh[i];
        if (mv[i]) occ++;
      end
      n_checks++;
      if (hold_o !== mhp) begin
        n_errors++; $display("FAIL rnd_hold@%0d: got %b expected %b", cyc, hold_o, mhp);
      end
      n_checks++;
      if (in_ready !== ~mh[0]) begin
        n_errors++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", cyc, in_ready, ~mh[0]);
      end
      n_checks++;
      if (stage_valid !== mvp) begin
        n_errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, stage_valid, mvp);
      end
      for (int i = 0; i < int'(N); i++) begin
        n_checks++;
        if (sd(i) !== md[i]) begin
          n_errors++; $display("FAIL rnd_data[%0d]@%0d: got %h expected %h", i, cyc, sd(i), md[i]);
        end
      end
      n_checks++;
      if (occupancy !== OW'(occ)) begin
        n_errors++; $display("FAIL rnd_occ@%0d: got %0d expected %0d", cyc, occupancy, occ);
      end
      n_checks++;
      if (out_valid !== mv[N-1] || out_data !== md[N-1]) begin
        n_errors++;
        $display("FAIL rnd_out@%0d: got %b/%h expected %b/%h", cyc, out_valid, out_data,
                 mv[N-1], md[N-1]);
      end
      n_checks++;
      if (front_stall_cnt !== CW'(mcnt)) begin
        n_errors++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", cyc, front_stall_cnt, mcnt);
      end
      for (int i = 0; i < int'(N); i++) begin
        if (fl[i]) begin
          nv[i] = 1'b0; nd[i] = FD;
        end else if (mh[i]) begin
          nv[i] = mv[i]; nd[i] = md[i];
        end else if (i > 0 && mh[i-1]) begin
          nv[i] = 1'b0; nd[i] = FD;
        end else if (i == 0) begin
          nv[i] = iv; nd[i] = id;
        end else begin
          nv[i] = mv[i-1]; nd[i] = md[i-1];
        end
      end
      if (iv && mh[0] && mcnt != 15) mcnt++;
      edge_step();
      for (int i = 0; i < int'(N); i++) begin
        mv[i] = nv[i]; md[i] = nd[i];
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_mid_stall();
    test_collapse();
    test_flush();
    test_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
